// File: rtl/wb_stage_pkg.sv
// Shared constants for the MEM/WB write-back stage.
//   LT_*     : load width/sign codes carried on LoadType
//   REG_ZERO : hard-wired zero register, never written
package wb_stage_pkg;

  localparam int unsigned LT_W = 3;

  localparam logic [LT_W-1:0] LT_LW  = 3'b000;
  localparam logic [LT_W-1:0] LT_LB  = 3'b001;
  localparam logic [LT_W-1:0] LT_LBU = 3'b010;
  localparam logic [LT_W-1:0] LT_LH  = 3'b011;
  localparam logic [LT_W-1:0] LT_LHU = 3'b100;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_stage_load_extender.sv
// Combinational load data extraction (little-endian).
// Ports:
//   i_raw       raw 32-bit word from data memory
//   i_off       byte offset within the word
//   i_load_type LT_* code; unknown codes behave as LW
//   o_data      extracted, sign/zero-extended 32-bit value
module load_extender
  import wb_stage_pkg::*;
(
  input  logic [31:0]     i_raw,
  input  logic [1:0]      i_off,
  input  logic [LT_W-1:0] i_load_type,
  output logic [31:0]     o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = '0;
    case (i_off)
      2'd0:    w_byte = i_raw[7:0];
      2'd1:    w_byte = i_raw[15:8];
      2'd2:    w_byte = i_raw[23:16];
      default: w_byte = i_raw[31:24];
    endcase
  end

  // Halfwords pick the half by off[1]; off[0] is ignored.
  assign w_half = i_off[1] ? i_raw[31:16] : i_raw[15:0];

  always_comb begin
    o_data = i_raw;
    case (i_load_type)
      LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  o_data = {24'd0, w_byte};
      LT_LH:   o_data = {{16{w_half[15]}}, w_half};
      LT_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back mux.
// Ports:
//   clock, reset (sync, active-high)
//   stall / flush        hold / invalidate stage contents (flush wins)
//   in_valid, RegWrite_in, MemtoReg_in, LoadType_in, write_reg_in,
//   alu_result_in, read_data_in      MEM-stage results
//   wb_valid, RegWrite_out, write_reg_out, write_data_out   register-file write port
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic [LT_W-1:0]   LoadType_in,
  input  logic [REG_AW-1:0] write_reg_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] read_data_in,
  output logic              wb_valid,
  output logic              RegWrite_out,
  output logic [REG_AW-1:0] write_reg_out,
  output logic [DATA_W-1:0] write_data_out
);

  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic [LT_W-1:0]   r_load_type;
  logic [REG_AW-1:0] r_write_reg;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_read_data;
  logic [31:0]       w_load_ext;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_load_type  <= '0;
      r_write_reg  <= '0;
      r_alu_result <= '0;
      r_read_data  <= '0;
    end else if (!stall) begin
      r_valid      <= in_valid;
      r_reg_write  <= RegWrite_in;
      r_mem_to_reg <= MemtoReg_in;
      r_load_type  <= LoadType_in;
      r_write_reg  <= write_reg_in;
      r_alu_result <= alu_result_in;
      r_read_data  <= read_data_in;
    end
  end

  load_extender u_load_extender (
    .i_raw       (r_read_data),
    .i_off       (r_alu_result[1:0]),
    .i_load_type (r_load_type),
    .o_data      (w_load_ext)
  );

  assign wb_valid       = r_valid;
  assign RegWrite_out   = r_valid & r_reg_write & (r_write_reg != REG_AW'(REG_ZERO));
  assign write_reg_out  = r_write_reg;
  assign write_data_out = r_mem_to_reg ? w_load_ext : r_alu_result;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clock = 1'b0;
  logic        reset, stall, flush, in_valid, RegWrite_in, MemtoReg_in;
  logic [2:0]  LoadType_in;
  logic [4:0]  write_reg_in;
  logic [31:0] alu_result_in, read_data_in;
  logic        wb_valid, RegWrite_out;
  logic [4:0]  write_reg_out;
  logic [31:0] write_data_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the stage should be holding.
  logic        m_v, m_rw, m_m2r;
  logic [2:0]  m_lt;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_raw;

  always #5 clock = ~clock;

  wb_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .LoadType_in(LoadType_in), .write_reg_in(write_reg_in),
    .alu_result_in(alu_result_in), .read_data_in(read_data_in),
    .wb_valid(wb_valid), .RegWrite_out(RegWrite_out),
    .write_reg_out(write_reg_out), .write_data_out(write_data_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] raw, input int off, input logic [2:0] lt);
    logic [31:0] b, h;
    b = (raw >> (8 * off)) & 32'hFF;
    h = (raw >> (16 * (off / 2))) & 32'hFFFF;
    case (lt)
      3'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return raw;
    endcase
  endfunction

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input logic rst, input logic stl, input logic fls, input logic v,
                      input logic rw, input logic m2r, input logic [2:0] lt,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] raw);
    logic [31:0] exp_data;
    reset = rst; stall = stl; flush = fls; in_valid = v; RegWrite_in = rw;
    MemtoReg_in = m2r; LoadType_in = lt; write_reg_in = rd;
    alu_result_in = alu; read_data_in = raw;
    @(posedge clock);
    if (rst || fls) begin
      m_v = 0; m_rw = 0; m_m2r = 0; m_lt = 0; m_rd = 0; m_alu = 0; m_raw = 0;
    end else if (!stl) begin
      m_v = v; m_rw = rw; m_m2r = m2r; m_lt = lt; m_rd = rd; m_alu = alu; m_raw = raw;
    end
    #1;
    check("wb_valid", {31'd0, wb_valid}, {31'd0, m_v});
    check("regwrite", {31'd0, RegWrite_out}, {31'd0, m_v && m_rw && (m_rd != 0)});
    check("write_reg", {27'd0, write_reg_out}, {27'd0, m_rd});
    if (m_v) begin
      exp_data = m_m2r ? ref_load(m_raw, int'(m_alu % 4), m_lt) : m_alu;
      check("write_data", write_data_out, exp_data);
    end
  endtask

  initial begin
    logic [31:0] rdw;
    rdw = 32'h80FF_7F01;

    // Reset: everything reads 0
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_data", write_data_out, 32'h0);

    // 1: ALU op
    step(0, 0, 0, 1, 1, 0, 0, 5, 32'h0000_1234, 0);
    check("alu_rw", {31'd0, RegWrite_out}, 32'd1);
    check("alu_data", write_data_out, 32'h0000_1234);

    // 2: loads
    step(0, 0, 0, 1, 1, 1, 3'd1, 7, 32'h1000_0003, rdw);
    check("lb_off3", write_data_out, 32'hFFFF_FF80);
    step(0, 0, 0, 1, 1, 1, 3'd2, 7, 32'h1000_0001, rdw);
    check("lbu_off1", write_data_out, 32'h0000_007F);
    step(0, 0, 0, 1, 1, 1, 3'd3, 7, 32'h1000_0002, rdw);
    check("lh_off2", write_data_out, 32'hFFFF_80FF);
    step(0, 0, 0, 1, 1, 1, 3'd4, 7, 32'h1000_0000, rdw);
    check("lhu_off0", write_data_out, 32'h0000_7F01);
    step(0, 0, 0, 1, 1, 1, 3'd0, 7, 32'h1000_0002, rdw);
    check("lw", write_data_out, 32'h80FF_7F01);
    step(0, 0, 0, 1, 1, 1, 3'd6, 7, 32'h1000_0001, rdw);
    check("lt_110_as_lw", write_data_out, 32'h80FF_7F01);

    // 3: rd=0 never written
    step(0, 0, 0, 1, 1, 0, 0, 0, 32'hDEAD_BEEF, 0);
    check("rd0_rw", {31'd0, RegWrite_out}, 32'd0);

    // 4: stall holds A, B appears after release
    step(0, 0, 0, 1, 1, 0, 0, 9, 32'hAAAA_0000, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 1, 0, 0, 10, 32'hBBBB_0000, 0);
      check("stall_hold", write_data_out, 32'hAAAA_0000);
    end
    step(0, 0, 0, 1, 1, 0, 0, 10, 32'hBBBB_0000, 0);
    check("stall_release", write_data_out, 32'hBBBB_0000);

    // 5: flush + stall
    step(0, 1, 1, 1, 1, 0, 0, 11, 32'h1111_1111, 0);
    check("flush_valid", {31'd0, wb_valid}, 32'd0);
    check("flush_rw", {31'd0, RegWrite_out}, 32'd0);

    // 6: reset mid-stream
    step(0, 0, 0, 1, 1, 0, 0, 12, 32'h2222_2222, 0);
    step(1, 0, 0, 1, 1, 0, 0, 13, 32'h3333_3333, 0);
    check("rst_mid_data", write_data_out, 32'h0);
    check("rst_mid_rw", {31'd0, RegWrite_out}, 32'd0);
    step(0, 0, 0, 1, 1, 0, 0, 14, 32'h4444_4444, 0);
    check("rst_resume", write_data_out, 32'h4444_4444);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
